// File: rtl/rect_plotter.sv
// rect_plotter: scans a latched width x height rectangle one pixel per unstalled cycle.
// Define RECT_PLOTTER_CLIP_EN to suppress plots of pixels outside SCREEN_W x SCREEN_H.
module rect_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset_state,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [4:0] width,
    input  logic [4:0] height,
    input  logic [2:0] colour_in,
    input  logic       stall,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic [4:0] counter_x,
    output logic [4:0] counter_y,
    output logic       busy,
    output logic       done
);
`ifdef RECT_PLOTTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

    state_t     state, state_next;
    logic [7:0] x_l;
    logic [6:0] y_l;
    logic [4:0] w_l, h_l, cx, cy;
    logic [2:0] col_l;
    logic [8:0] ux;
    logic [7:0] uy;
    logic       visible, last_col, last_row, step;

    always_comb begin
        ux = {1'b0, x_l} + 9'(cx);
        uy = {1'b0, y_l} + 8'(cy);
        visible = (32'(ux) < SCREEN_W) && (32'(uy) < SCREEN_H);
        last_col = cx == w_l - 5'd1;
        last_row = cy == h_l - 5'd1;
        step = state == DRAW && !stall;
        state_next = state;
        case (state)
            IDLE:    state_next = start ? LOAD : IDLE;
            LOAD:    state_next = (width == 5'd0 || height == 5'd0) ? FINISH : DRAW;
            DRAW:    state_next = (step && last_col && last_row) ? FINISH : DRAW;
            default: state_next = IDLE;
        endcase
        busy = state != IDLE;
        done = state == FINISH;
        plot = step && (!CLIP || visible);
        x_out = ux[7:0];
        y_out = uy[6:0];
        colour_out = col_l;
        counter_x = cx;
        counter_y = cy;
    end

    always_ff @(posedge clock or posedge reset_state) begin
        if (reset_state) begin
            state <= IDLE;
            x_l   <= '0;
            y_l   <= '0;
            w_l   <= '0;
            h_l   <= '0;
            col_l <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_next;
            if (state == LOAD) begin
                x_l   <= x_in;
                y_l   <= y_in;
                w_l   <= width;
                h_l   <= height;
                col_l <= colour_in;
                cx    <= '0;
                cy    <= '0;
            end else if (step) begin
                cx <= last_col ? 5'd0 : cx + 5'd1;
                if (last_col && !last_row)
                    cy <= cy + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: table vectors, reset abort sequence and randomized draws vs a pixel-timeline model.
module tb_rect_plotter;
    localparam int SW = 160, SH = 120, MAXC = 4096;
`ifdef RECT_PLOTTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_state, start, stall;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [4:0] width, height;
    logic [2:0] colour_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;
    logic [4:0] counter_x, counter_y;

    int n_checks = 0, n_fail = 0;

    rect_plotter #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock(clock), .reset_state(reset_state), .start(start),
        .x_in(x_in), .y_in(y_in), .width(width), .height(height),
        .colour_in(colour_in), .stall(stall), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .plot(plot), .counter_x(counter_x),
        .counter_y(counter_y), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x, y, w, h, col, st_after, st_len, mode, exp_plots, exp_done;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
        end
    endtask

    // mode 0: single start; 1: extra starts at cycle 5 and in FINISH; 2: random starts while busy
    task automatic run(input int x, y, w, h, col, st_after, st_len, mode, input bit rnd,
                       output int np, output int dc, output int m_np, output int m_dc);
        bit st[MAXC];
        bit dr[MAXC];
        bit ep[MAXC];
        int ecx[MAXC];
        int ecy[MAXC];
        int c, p, used;
        bit s;
        for (int i = 0; i < MAXC; i++) begin
            st[i] = 0; dr[i] = 0; ep[i] = 0; ecx[i] = 0; ecy[i] = 0;
        end
        c = 2; p = 0; used = 0; m_np = 0;
        while (p < w * h && c < MAXC - 2) begin
            s = rnd ? ($urandom_range(3) == 0) : (p == st_after && used < st_len);
            if (s) used++;
            st[c] = s;
            dr[c] = 1;
            ecx[c] = p % w;
            ecy[c] = p / w;
            ep[c] = !s && (!CLIP || (x + p % w < SW && y + p / w < SH));
            if (ep[c]) m_np++;
            if (!s) p++;
            c++;
        end
        m_dc = c;
        np = 0;
        dc = -1;
        for (int k = 0; k <= m_dc + 1; k++) begin
            @(posedge clock);
            #1;
            start = (k == 0) || (mode == 1 && (k == 5 || k == m_dc)) ||
                    (mode == 2 && k >= 2 && k <= m_dc && $urandom_range(1) == 1);
            if (k < 2) begin
                x_in = 8'(x); y_in = 7'(y); width = 5'(w); height = 5'(h); colour_in = 3'(col);
            end else begin
                x_in = 8'($urandom); y_in = 7'($urandom); width = 5'($urandom);
                height = 5'($urandom); colour_in = 3'($urandom);
            end
            stall = dr[k] ? st[k] : 1'($urandom);
            @(negedge clock);
            chk("plot", plot, ep[k]);
            chk("done", done, k == m_dc);
            chk("busy", busy, k >= 1 && k <= m_dc);
            if (dr[k]) begin
                chk("counter_x", counter_x, ecx[k]);
                chk("counter_y", counter_y, ecy[k]);
                chk("x_out", x_out, (x + ecx[k]) % 256);
                chk("y_out", y_out, (y + ecy[k]) % 128);
            end
            if (ep[k]) chk("colour_out", colour_out, col);
            if (plot) np++;
            if (done && dc < 0) dc = k;
        end
        start = 0;
    endtask

    initial begin
        int np, dc, m_np, m_dc;
        vecs[0] = '{10, 100, 20, 2, 7, -1, 0, 0, 40, 42};
        vecs[1] = '{5, 5, 0, 5, 3, -1, 0, 0, 0, 2};
        vecs[2] = '{0, 0, 4, 1, 2, 2, 3, 0, 4, 9};
        vecs[3] = '{150, 0, 20, 1, 5, -1, 0, 0, CLIP ? 10 : 20, 22};
        vecs[4] = '{10, 100, 20, 2, 1, -1, 0, 1, 40, 42};
        vecs[5] = '{250, 120, 10, 10, 6, -1, 0, 0, CLIP ? 0 : 100, 102};
        vecs[6] = '{3, 4, 1, 1, 4, -1, 0, 0, 1, 3};
        vecs[7] = '{0, 0, 31, 31, 7, -1, 0, 0, 961, 963};
        vecs[8] = '{7, 7, 5, 0, 1, -1, 0, 0, 0, 2};
        reset_state = 1; start = 0; stall = 0;
        x_in = 0; y_in = 0; width = 0; height = 0; colour_in = 0;
        repeat (2) @(negedge clock);
        chk("rst_plot", plot, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_x", x_out, 0); chk("rst_y", y_out, 0); chk("rst_col", colour_out, 0);
        chk("rst_cx", counter_x, 0); chk("rst_cy", counter_y, 0);
        reset_state = 0;
        foreach (vecs[i]) begin
            run(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].col, vecs[i].st_after,
                vecs[i].st_len, vecs[i].mode, 0, np, dc, m_np, m_dc);
            chk($sformatf("vec%0d_plots", i), np, vecs[i].exp_plots);
            chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
        end
        // abort an 8x8 draw with an asynchronous reset in cycle 10
        @(posedge clock);
        #1;
        start = 1; x_in = 10; y_in = 20; width = 8; height = 8; colour_in = 3; stall = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            start = 0;
            @(negedge clock);
        end
        chk("pre_reset_plot", plot, 1);
        @(posedge clock);
        #3 reset_state = 1;
        #1;
        chk("abort_plot", plot, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        chk("abort_x", x_out, 0); chk("abort_cx", counter_x, 0);
        repeat (3) begin
            @(negedge clock);
            chk("held_done", done, 0);
            chk("held_busy", busy, 0);
        end
        reset_state = 0;
        run(10, 20, 8, 8, 3, -1, 0, 0, 0, np, dc, m_np, m_dc);
        chk("post_reset_plots", np, 64);
        chk("post_reset_done_cycle", dc, 66);
        for (int r = 0; r < 12; r++) begin
            run($urandom_range(255), $urandom_range(127), $urandom_range(31), $urandom_range(31),
                $urandom_range(7), -1, 0, 2, 1, np, dc, m_np, m_dc);
            chk($sformatf("rnd%0d_plots", r), np, m_np);
            chk($sformatf("rnd%0d_done_cycle", r), dc, m_dc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
